// File: rtl/bmp_slave_tx.sv
// bmp_slave_tx: transmit end of the scheduler's slave port.
// Streams a BMP image byte-wise out of a local memory and packs four bytes per
// 32-bit word (first byte in the MSB). The image length is taken from header
// bytes 2..5 while they stream past. At least HDR_BYTES bytes are always sent.
// Optional feature macro: BMP_TX_ABORT_EN adds the abort input and aborted pulse.
module bmp_slave_tx #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned HDR_BYTES = 56,
    parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cfg_mode,
    input  logic [7:0]        cfg_data_proc,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [1:0]        slv_mode,
    output logic              slv_data_valid,
    output logic [31:0]       slv_data,
    output logic [7:0]        slv_data_proc,
    input  logic              slv_ready,
    output logic              busy,
    output logic              done,
    output logic              size_err
`ifdef BMP_TX_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    localparam logic [31:0] HDR_W = 32'(HDR_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic [2:0]        phase_r;
    logic [31:0]       byte_idx_r;
    logic [ADDR_W-1:0] base_r;
    logic [31:0]       file_size_r;
    logic              size_known_r;
    logic [3:0]        rd_flag_r;
    logic [31:0]       word_r;
    logic [1:0]        mode_r;
    logic [7:0]        proc_r;
    logic              valid_r;
    logic              done_r;
    logic              busy_r;
    logic              mem_rd_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              size_err_r;
`ifdef BMP_TX_ABORT_EN
    logic              aborted_r;
`endif

    logic [31:0] eff_size_s;
    logic [2:0]  cap_slot_s;
    logic [31:0] slot_idx_s;
    logic [31:0] cap_idx_s;
    logic        issue_en_s;
    logic        cap_en_s;
    logic [31:0] word_nxt_s;
    logic [31:0] size_upd_s;
    logic        size_done_s;
    logic [31:0] next_idx_s;

    // Write byte b into word slot k (slot 0 is the MSB).
    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (k)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            2'd3:    r[7:0]   = b;
            default: r        = w;
        endcase
        return r;
    endfunction

    // Fetch-phase decode: which slot is issued, which is captured, and the size bytes.
    // Phases 0..3 issue the read (or pad) for slot == phase; phases 2..5 capture
    // the byte for slot == phase-2 because the read strobe is registered.
    always_comb begin
        eff_size_s  = 32'hFFFF_FFFF;
        cap_slot_s  = phase_r - 3'd2;
        slot_idx_s  = byte_idx_r + {29'd0, phase_r};
        cap_idx_s   = byte_idx_r + {29'd0, cap_slot_s};
        issue_en_s  = 1'b0;
        cap_en_s    = 1'b0;
        word_nxt_s  = word_r;
        size_upd_s  = file_size_r;
        size_done_s = 1'b0;
        next_idx_s  = byte_idx_r + 32'd4;

        if (size_known_r) begin
            eff_size_s = (file_size_r < HDR_W) ? HDR_W : file_size_r;
        end else begin
            eff_size_s = 32'hFFFF_FFFF;
        end

        if (phase_r <= 3'd3) begin
            issue_en_s = (slot_idx_s < eff_size_s);
            if (!issue_en_s) begin
                word_nxt_s = put_byte(word_nxt_s, phase_r[1:0], PAD_BYTE);
            end else begin
                word_nxt_s = word_nxt_s;
            end
        end else begin
            issue_en_s = 1'b0;
        end

        if (phase_r >= 3'd2) begin
            cap_en_s = rd_flag_r[cap_slot_s[1:0]];
        end else begin
            cap_en_s = 1'b0;
        end

        if (cap_en_s) begin
            word_nxt_s = put_byte(word_nxt_s, cap_slot_s[1:0], mem_rdata);
            if (cap_idx_s[31:3] == 29'd0) begin
                case (cap_idx_s[2:0])
                    3'd2:    size_upd_s[7:0]   = mem_rdata;
                    3'd3:    size_upd_s[15:8]  = mem_rdata;
                    3'd4:    size_upd_s[23:16] = mem_rdata;
                    3'd5:    size_upd_s[31:24] = mem_rdata;
                    default: size_upd_s        = file_size_r;
                endcase
                size_done_s = (cap_idx_s[2:0] == 3'd5);
            end else begin
                size_done_s = 1'b0;
            end
        end else begin
            size_done_s = 1'b0;
        end
    end

    // Main controller: state sequencing and every registered output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            phase_r      <= 3'd0;
            byte_idx_r   <= 32'd0;
            base_r       <= '0;
            file_size_r  <= 32'd0;
            size_known_r <= 1'b0;
            rd_flag_r    <= 4'd0;
            word_r       <= 32'd0;
            mode_r       <= 2'b00;
            proc_r       <= 8'd0;
            valid_r      <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            mem_rd_r     <= 1'b0;
            mem_addr_r   <= '0;
            size_err_r   <= 1'b0;
`ifdef BMP_TX_ABORT_EN
            aborted_r    <= 1'b0;
        end else if (abort && (state_r != ST_IDLE)) begin
            // Abort wins over an accept in the same cycle: the word is dropped.
            state_r   <= ST_IDLE;
            phase_r   <= 3'd0;
            valid_r   <= 1'b0;
            mode_r    <= 2'b00;
            mem_rd_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b1;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef BMP_TX_ABORT_EN
            aborted_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (start && ((cfg_mode == 2'b01) || (cfg_mode == 2'b10))) begin
                        mode_r       <= cfg_mode;
                        proc_r       <= cfg_data_proc;
                        base_r       <= cfg_base;
                        byte_idx_r   <= 32'd0;
                        phase_r      <= 3'd0;
                        file_size_r  <= 32'd0;
                        size_known_r <= 1'b0;
                        size_err_r   <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    mem_rd_r <= issue_en_s;
                    if (issue_en_s) begin
                        mem_addr_r <= base_r + byte_idx_r[ADDR_W-1:0] + ADDR_W'(phase_r);
                    end
                    if (phase_r <= 3'd3) begin
                        rd_flag_r[phase_r[1:0]] <= issue_en_s;
                    end
                    word_r      <= word_nxt_s;
                    file_size_r <= size_upd_s;
                    if (size_done_s) begin
                        size_known_r <= 1'b1;
                        size_err_r   <= (size_upd_s < HDR_W);
                    end
                    if (phase_r == 3'd5) begin
                        phase_r <= 3'd0;
                        valid_r <= 1'b1;
                        state_r <= ST_SEND;
                    end else begin
                        phase_r <= phase_r + 3'd1;
                    end
                end
                ST_SEND: begin
                    if (slv_ready) begin
                        valid_r    <= 1'b0;
                        byte_idx_r <= next_idx_s;
                        if (next_idx_s >= eff_size_s) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    mode_r  <= 2'b00;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd         = mem_rd_r;
    assign mem_addr       = mem_addr_r;
    assign slv_mode       = mode_r;
    assign slv_data_valid = valid_r;
    assign slv_data       = word_r;
    assign slv_data_proc  = proc_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign size_err       = size_err_r;
`ifdef BMP_TX_ABORT_EN
    assign aborted        = aborted_r;
`endif

endmodule

// File: tb/tb_bmp_slave_tx.sv
// Bench for bmp_slave_tx: a byte-array image memory, a word-list model built
// from the image rules, and a per-cycle compare process on the falling edge.
module tb_bmp_slave_tx;

    localparam int unsigned HDR = 56;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_data_proc;
    logic [15:0] cfg_base;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [1:0]  slv_mode;
    logic        slv_data_valid;
    logic [31:0] slv_data;
    logic [7:0]  slv_data_proc;
    logic        slv_ready;
    logic        busy;
    logic        done;
    logic        size_err;
`ifdef BMP_TX_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    bmp_slave_tx dut (
        .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode),
        .cfg_data_proc(cfg_data_proc), .cfg_base(cfg_base),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .slv_mode(slv_mode), .slv_data_valid(slv_data_valid), .slv_data(slv_data),
        .slv_data_proc(slv_data_proc), .slv_ready(slv_ready),
        .busy(busy), .done(done), .size_err(size_err)
`ifdef BMP_TX_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];

    // Image memory: read data valid exactly one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    int          vectors = 0;
    int          miscompares = 0;
    int          ready_mode = 0;
    bit          active = 1'b0;
    logic [1:0]  exp_mode;
    logic [7:0]  exp_proc;
    logic [15:0] exp_base;
    int unsigned exp_eff;
    bit          exp_serr;
    int unsigned rd_ptr;
    logic [31:0] expq[$];
    int          words_seen;
    bit          exp_done_next = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [31:0] first_word;
    logic [31:0] last_word;
    bit          exp_aborted = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready generator: always-on, random, or held low.
    initial begin
        slv_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       slv_ready = 1'b1;
                1:       slv_ready = ($urandom_range(0, 3) != 0);
                default: slv_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit          dn;
        logic [31:0] w;
        if (!reset) begin
            exp_done_next = 1'b0;
            prev_hold = 1'b0;
        end else begin
            check("busy", {31'd0, busy}, {31'd0, active});
            check("done", {31'd0, done}, {31'd0, exp_done_next});
            if (active) begin
                check("mode", {30'd0, slv_mode}, {30'd0, exp_mode});
                check("data_proc", {24'd0, slv_data_proc}, {24'd0, exp_proc});
            end else begin
                check("mode_idle", {30'd0, slv_mode}, 32'd0);
                check("valid_idle", {31'd0, slv_data_valid}, 32'd0);
            end
`ifdef BMP_TX_ABORT_EN
            check("aborted", {31'd0, aborted}, {31'd0, exp_aborted});
`endif
            if (prev_hold) begin
                check("hold_valid", {31'd0, slv_data_valid}, 32'd1);
                check("hold_data", slv_data, prev_data);
            end
            if (mem_rd) begin
                if (!active || rd_ptr >= exp_eff) begin
                    check("mem_rd_unexpected", {31'd0, mem_rd}, 32'd0);
                end else begin
                    check("mem_addr", {16'd0, mem_addr}, {16'd0, 16'(exp_base + 16'(rd_ptr))});
                    rd_ptr++;
                end
            end
            if (exp_done_next) begin
                check("size_err", {31'd0, size_err}, {31'd0, exp_serr});
                check("read_count", rd_ptr, exp_eff);
                active = 1'b0;
            end
            dn = 1'b0;
            if (slv_data_valid && slv_ready) begin
                if (expq.size() == 0) begin
                    check("extra_word", 32'd1, 32'd0);
                end else begin
                    w = expq.pop_front();
                    check("word", slv_data, w);
                    words_seen++;
                    if (words_seen == 1) first_word = slv_data;
                    last_word = slv_data;
                    dn = (expq.size() == 0);
                end
            end
            exp_done_next = dn;
            prev_hold = slv_data_valid && !slv_ready;
            prev_data = slv_data;
        end
    end

    // Fill an image: 'BM', little-endian size, random body.
    task automatic prep_mem(input logic [15:0] base, input int unsigned size);
        int unsigned eff;
        eff = (size < HDR) ? HDR : size;
        for (int unsigned i = 0; i < eff + 8; i++) mem[16'(base + 16'(i))] = 8'($urandom);
        mem[base] = 8'h42;
        mem[16'(base + 16'd1)] = 8'h4D;
        mem[16'(base + 16'd2)] = size[7:0];
        mem[16'(base + 16'd3)] = size[15:8];
        mem[16'(base + 16'd4)] = size[23:16];
        mem[16'(base + 16'd5)] = size[31:24];
    endtask

    // Build the expected word list from memory contents, then pulse start.
    task automatic start_image(input logic [15:0] base, input logic [1:0] mode, input logic [7:0] proc);
        logic [31:0] fs;
        logic [31:0] w;
        int unsigned idx;
        fs = {mem[16'(base + 16'd5)], mem[16'(base + 16'd4)], mem[16'(base + 16'd3)], mem[16'(base + 16'd2)]};
        exp_eff = (fs < HDR) ? HDR : fs;
        exp_serr = (fs < HDR);
        expq.delete();
        for (int unsigned n = 0; n < (exp_eff + 3) / 4; n++) begin
            w = 32'd0;
            for (int unsigned k = 0; k < 4; k++) begin
                idx = 4 * n + k;
                w = {w[23:0], (idx < exp_eff) ? mem[16'(base + 16'(idx))] : 8'h00};
            end
            expq.push_back(w);
        end
        exp_base = base;
        exp_mode = mode;
        exp_proc = proc;
        rd_ptr = 0;
        words_seen = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_mode = mode;
        cfg_data_proc = proc;
        cfg_base = base;
        @(posedge clk);
        active = 1'b1;
        #1;
        start = 1'b0;
        cfg_mode = 2'b00;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (active && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (active) begin
            check("image_timeout", 32'd1, 32'd0);
            active = 1'b0;
            expq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        cfg_mode = 2'b00;
        cfg_data_proc = 8'h00;
        cfg_base = 16'h0000;
`ifdef BMP_TX_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, slv_data_valid}, 32'd0);
        check("rst_data", slv_data, 32'd0);
        check("rst_mode", {30'd0, slv_mode}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_size_err", {31'd0, size_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Full 58-byte image with continuous ready.
        ready_mode = 0;
        prep_mem(16'h0100, 58);
        mem[16'h0100 + 16'd56] = 8'hA5;
        mem[16'h0100 + 16'd57] = 8'h5A;
        start_image(16'h0100, 2'b01, 8'h80);
        wait_done(3000);
        check("t2_words", words_seen, 32'd15);
        check("t2_word0", first_word, 32'h424D_3A00);
        check("t2_word14", last_word, 32'hA55A_0000);
        check("t2_size_err", {31'd0, size_err}, 32'd0);

        // Undersize header: 40 bytes claimed, 56 sent.
        prep_mem(16'h0200, 40);
        start_image(16'h0200, 2'b10, 8'h11);
        wait_done(3000);
        check("t4_words", words_seen, 32'd14);
        check("t4_size_err", {31'd0, size_err}, 32'd1);

        // Rejected mode 11.
        @(posedge clk);
        #1 start = 1'b1;
        cfg_mode = 2'b11;
        @(posedge clk);
        #1 start = 1'b0;
        cfg_mode = 2'b00;
        repeat (3) @(negedge clk);
        check("t5_badmode_busy", {31'd0, busy}, 32'd0);

        // Start while busy is ignored.
        prep_mem(16'h0400, 70);
        start_image(16'h0400, 2'b10, 8'h5C);
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        cfg_mode = 2'b01;
        cfg_base = 16'h9000;
        cfg_data_proc = 8'hEE;
        @(posedge clk);
        #1 start = 1'b0;
        cfg_mode = 2'b00;
        wait_done(3000);
        check("t5_words", words_seen, 32'd18);

        // Backpressure: ready low 7 cycles while word 3 is presented.
        prep_mem(16'h0600, 64);
        start_image(16'h0600, 2'b01, 8'h33);
        fork
            wait_done(3000);
            begin
                n = 0;
                while (words_seen < 3 && n < 2000) begin @(negedge clk); n++; end
                ready_mode = 2;
                n = 0;
                while (!slv_data_valid && n < 50) begin @(negedge clk); n++; end
                check("t3_valid_seen", {31'd0, slv_data_valid}, 32'd1);
                repeat (7) @(negedge clk);
                ready_mode = 0;
            end
        join
        check("t3_words", words_seen, 32'd16);

        // Reset for two cycles while a word waits in SEND.
        ready_mode = 2;
        prep_mem(16'h0800, 60);
        start_image(16'h0800, 2'b01, 8'h01);
        n = 0;
        while (!slv_data_valid && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 reset = 1'b0;
        active = 1'b0;
        expq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_valid", {31'd0, slv_data_valid}, 32'd0);
        check("t1_mode", {30'd0, slv_mode}, 32'd0);
        check("t1_data", slv_data, 32'd0);
        check("t1_size_err", {31'd0, size_err}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        ready_mode = 0;
        start_image(16'h0800, 2'b01, 8'h01);
        wait_done(3000);
        check("t1_words", words_seen, 32'd15);
        check("t1_word0", first_word[31:16], 32'h0000_424D);

        // Random images with random ready, including address wrap.
        ready_mode = 1;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] b;
            b = (i == 0) ? 16'hFFE0 : 16'($urandom_range(0, 65000));
            prep_mem(b, $urandom_range(30, 160));
            start_image(b, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, 8'($urandom));
            wait_done(6000);
        end
        ready_mode = 0;

`ifdef BMP_TX_ABORT_EN
        // Abort during the fetch of word 5.
        prep_mem(16'h3000, 100);
        start_image(16'h3000, 2'b01, 8'h77);
        n = 0;
        while (words_seen < 5 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        active = 1'b0;
        expq.delete();
        exp_aborted = 1'b1;
        #1 abort = 1'b0;
        @(negedge clk);
        check("t6_valid", {31'd0, slv_data_valid}, 32'd0);
        check("t6_mode", {30'd0, slv_mode}, 32'd0);
        check("t6_aborted", {31'd0, aborted}, 32'd1);
        @(posedge clk);
        exp_aborted = 1'b0;
        repeat (20) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
